// File: rtl/fw_wishbone_sram_arbiter_if.sv
// rtl/fw_wishbone_sram_arbiter_if.sv - Wishbone bundle of N lanes used on both sides of the SRAM arbiter
//
// Purpose: groups the Wishbone handshake/bus signals of N initiator lanes.
//   Lane k occupies adr[k*AW +: AW], dat_w/dat_r[k*DW +: DW], sel[k*DW/8 +: DW/8],
//   tgc[k*4 +: 4] and bit k of cyc/stb/we/ack.
// Ports (modports):
//   master : drives adr, dat_w, cyc, stb, we, sel, tgc; receives dat_r, ack
//   slave  : receives adr, dat_w, cyc, stb, we, sel, tgc; drives dat_r, ack
interface fw_wishbone_sram_arbiter_if #(
  parameter int N  = 1,
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [N*AW-1:0]     adr;
  logic [N*DW-1:0]     dat_w;
  logic [N*DW-1:0]     dat_r;
  logic [N-1:0]        cyc;
  logic [N-1:0]        stb;
  logic [N-1:0]        we;
  logic [N*(DW/8)-1:0] sel;
  logic [N*4-1:0]      tgc;
  logic [N-1:0]        ack;

  modport master (output adr, dat_w, cyc, stb, we, sel, tgc, input dat_r, ack);
  modport slave  (input adr, dat_w, cyc, stb, we, sel, tgc, output dat_r, ack);
endinterface

// File: rtl/fw_wishbone_sram_arbiter.sv
// rtl/fw_wishbone_sram_arbiter.sv - round-robin Wishbone arbiter in front of a single-port SRAM controller
//
// Purpose: forwards exactly one initiator's Wishbone cycle (including the AMO
//   cycle tag) to the SRAM controller at a time. A grant covers one transfer and
//   is released on the downstream ack or when the owner drops cyc.
// Ports:
//   clock    : single clock, all state on posedge
//   reset_n  : asynchronous active-low reset
//   t        : upstream initiators (N_PORTS lanes, slave side)
//   i        : downstream SRAM controller target port (one lane, master side)
//   grant    : one-hot current owner, 0 when idle
module fw_wishbone_sram_arbiter #(
  parameter int N_PORTS   = 2,
  parameter int ADR_WIDTH = 32,
  parameter int DAT_WIDTH = 32
) (
  input  logic                        clock,
  input  logic                        reset_n,
  fw_wishbone_sram_arbiter_if.slave   t,
  fw_wishbone_sram_arbiter_if.master  i,
  output logic [N_PORTS-1:0]          grant
);

  localparam int SW = DAT_WIDTH / 8;
  localparam int IW = $clog2(N_PORTS);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state, state_nxt;
  logic [N_PORTS-1:0] grant_nxt;
  logic [IW-1:0]      last, last_nxt;
  logic [IW-1:0]      gidx;
  logic [IW-1:0]      pick;
  logic               pick_vld;
  logic [N_PORTS-1:0] req;

  assign req = t.cyc & t.stb;

  // Index of the current owner; only meaningful while BUSY.
  always_comb begin
    gidx = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      if (grant[k]) gidx = IW'(k);
    end
  end

  // Round-robin search starting at last+1. The loop walks the offsets from the
  // farthest to the nearest so the nearest requester is the final assignment.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int off = N_PORTS; off >= 1; off--) begin
      if (req[(int'(last) + off) % N_PORTS]) begin
        pick     = IW'((int'(last) + off) % N_PORTS);
        pick_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      grant <= '0;
      last  <= IW'(N_PORTS - 1);
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      last  <= last_nxt;
    end
  end

  // The grant is held until the controller acks, which keeps AMO read and
  // write-back phases indivisible. Dropping cyc abandons the transfer; either
  // way the owner becomes 'last' so the other ports are served next.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    last_nxt  = last;
    case (state)
      IDLE: begin
        grant_nxt = '0;
        if (pick_vld) begin
          state_nxt       = BUSY;
          grant_nxt[pick] = 1'b1;
        end
      end
      BUSY: begin
        if (!t.cyc[gidx] || i.ack[0]) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          last_nxt  = gidx;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  // Downstream mux follows the owner's inputs combinationally, so an abort
  // drops i.cyc in the same cycle the initiator drops its cyc.
  always_comb begin
    i.cyc   = 1'b0;
    i.stb   = 1'b0;
    i.we    = 1'b0;
    i.adr   = '0;
    i.dat_w = '0;
    i.sel   = '0;
    i.tgc   = '0;
    t.ack   = '0;
    if (state == BUSY) begin
      i.cyc   = t.cyc[gidx];
      i.stb   = t.stb[gidx];
      i.we    = t.we[gidx];
      i.adr   = t.adr[gidx*ADR_WIDTH +: ADR_WIDTH];
      i.dat_w = t.dat_w[gidx*DAT_WIDTH +: DAT_WIDTH];
      i.sel   = t.sel[gidx*SW +: SW];
      i.tgc   = t.tgc[gidx*4 +: 4];
      t.ack   = grant & {N_PORTS{i.ack[0]}};
    end
  end

  assign t.dat_r = {N_PORTS{i.dat_r}};

endmodule
